tug_field: RTL and testbench

Parametrised tug-of-war playfield for the FPGA game. It replaces the per-light centre/neighbour FSM chain with a single position register driving `NUM_LIGHTS` LEDs. It detects key-press edges, moves the lit LED toward the pressing player, and declares a winner when the light is pushed off an end. It also keeps saturating per-player scores and re-centres automatically after a fixed restart delay. It sits between the synchronised key inputs and the LED/hex display logic.

---
 rtl/tug_field.sv | 121 ++++++++++++
 tb/tb_tug_field.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tug_field.sv
// Tug-of-war playfield: one position register drives a one-hot LED bar, key-press
// edges push the light toward the pressing player, and wins are scored and timed out.
module tug_field #(
  parameter int NUM_LIGHTS     = 9,
  parameter int RESTART_CYCLES = 4,
  parameter int SCORE_W        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic                  left_win,
  output logic                  right_win,
  output logic [SCORE_W-1:0]    left_score,
  output logic [SCORE_W-1:0]    right_score
);

  localparam int POS_W = $clog2(NUM_LIGHTS);
  localparam int CNT_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

  localparam logic [POS_W-1:0]   POS_C     = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(NUM_LIGHTS - 1);
  localparam logic [POS_W-1:0]   POS_ONE   = POS_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(RESTART_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  typedef enum logic [1:0] {PLAY, WIN_L, WIN_R} state_e;

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] left_score_q, left_score_d;
  logic [SCORE_W-1:0] right_score_q, right_score_d;
  logic               l_prev_q, l_prev_d;
  logic               r_prev_q, r_prev_d;

  logic lp, rp;

  assign lp = L & ~l_prev_q;
  assign rp = R & ~r_prev_q;

  // Prev registers reset high so a key held through reset never counts as a press.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      state_q       <= PLAY;
      pos_q         <= POS_C;
      cnt_q         <= '0;
      left_score_q  <= '0;
      right_score_q <= '0;
      l_prev_q      <= 1'b1;
      r_prev_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      cnt_q         <= cnt_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      l_prev_q      <= l_prev_d;
      r_prev_q      <= r_prev_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first so no path through this block infers a latch.
    state_d       = state_q;
    pos_d         = pos_q;
    cnt_d         = cnt_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    l_prev_d      = L;
    r_prev_d      = R;

    unique case (state_q)
      PLAY: begin
        if (lp && !rp) begin
          if (pos_q == POS_MAX) begin
            state_d      = WIN_L;
            left_score_d = (left_score_q == SCORE_MAX) ? left_score_q : left_score_q + SCORE_ONE;
          end else begin
            pos_d = pos_q + POS_ONE;
          end
        end else if (rp && !lp) begin
          if (pos_q == '0) begin
            state_d       = WIN_R;
            right_score_d = (right_score_q == SCORE_MAX) ? right_score_q : right_score_q + SCORE_ONE;
          end else begin
            pos_d = pos_q - POS_ONE;
          end
        end
      end
      // Press events are deliberately ignored while a win is displayed.
      WIN_L, WIN_R: begin
        if (cnt_q == CNT_LAST) begin
          state_d = PLAY;
          pos_d   = POS_C;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_comb begin
    leds = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      leds[i] = (state_q == PLAY) && (pos_q == POS_W'(i));
    end
    left_win  = (state_q == WIN_L);
    right_win = (state_q == WIN_R);
  end

  assign left_score  = left_score_q;
  assign right_score = right_score_q;

endmodule

// File: tb/tb_tug_field.sv
// Self-checking bench for tug_field: directed scenarios plus randomized key traffic
// compared against a behavioural game model.
module tb_tug_field;

  localparam int NL   = 5;
  localparam int RC   = 4;
  localparam int SW   = 2;
  localparam int SMAX = (1 << SW) - 1;
  localparam int CTR  = (NL - 1) / 2;
  localparam int VW   = NL + 2 + 2 * SW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          L = 1'b0;
  logic          R = 1'b0;
  logic [NL-1:0] leds;
  logic          left_win;
  logic          right_win;
  logic [SW-1:0] left_score;
  logic [SW-1:0] right_score;
  logic [VW-1:0] got_vec;

  tug_field #(
    .NUM_LIGHTS    (NL),
    .RESTART_CYCLES(RC),
    .SCORE_W       (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .L          (L),
    .R          (R),
    .leds       (leds),
    .left_win   (left_win),
    .right_win  (right_win),
    .left_score (left_score),
    .right_score(right_score)
  );

  always #5 clk = ~clk;

  assign got_vec = {leds, left_win, right_win, left_score, right_score};

  int n_checks = 0;
  int n_pass   = 0;

  // Game model: who has won (0 none, 1 left, 2 right) and how many win cycles remain.
  int m_pos, m_win, m_timer, m_ls, m_rs;
  bit m_lprev, m_rprev;

  task automatic model_edge(input bit l, input bit r, input bit rst);
    bit press_l, press_r;
    if (rst) begin
      m_pos = CTR; m_win = 0; m_timer = 0; m_ls = 0; m_rs = 0;
      m_lprev = 1'b1; m_rprev = 1'b1;
      return;
    end
    press_l = l && !m_lprev;
    press_r = r && !m_rprev;
    if (m_win != 0) begin
      m_timer = m_timer - 1;
      if (m_timer == 0) begin
        m_win = 0;
        m_pos = CTR;
      end
    end else if (press_l && !press_r) begin
      if (m_pos == NL - 1) begin
        m_win = 1; m_timer = RC;
        m_ls = (m_ls + 1 > SMAX) ? SMAX : m_ls + 1;
      end else m_pos = m_pos + 1;
    end else if (press_r && !press_l) begin
      if (m_pos == 0) begin
        m_win = 2; m_timer = RC;
        m_rs = (m_rs + 1 > SMAX) ? SMAX : m_rs + 1;
      end else m_pos = m_pos - 1;
    end
    m_lprev = l;
    m_rprev = r;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [NL-1:0] lv;
    lv = (m_win != 0) ? '0 : (NL'(1) << m_pos);
    return {lv, m_win == 1, m_win == 2, SW'(m_ls), SW'(m_rs)};
  endfunction

  // Drive inputs, take one rising edge, advance the model, then settle past the edge.
  task automatic step(input bit l, input bit r, input bit rst);
    L = l; R = r; reset = rst;
    @(posedge clk);
    model_edge(l, r, rst);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (got_vec !== {5'b00100, 1'b0, 1'b0, 2'd0, 2'd0})
      $display("FAIL reset_state: got %b want %b", got_vec, {5'b00100, 1'b0, 1'b0, 2'd0, 2'd0});
    else n_pass++;
    n_checks++;
    if (got_vec !== exp_vec()) $display("FAIL reset_model: got %b want %b", got_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (leds !== 5'b01000) $display("FAIL hold_one_move[%0d]: got %b want 01000", i, leds);
      else n_pass++;
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (leds !== 5'b10000) $display("FAIL repress_move: got %b want 10000", leds);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_cancel();
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (leds !== 5'b00100) $display("FAIL cancel: got %b want 00100", leds);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (leds !== 5'b00010) $display("FAIL right_move: got %b want 00010", leds);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_left_win();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (leds !== 5'b01000) $display("FAIL lwin_step1: got %b want 01000", leds);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (leds !== 5'b10000) $display("FAIL lwin_step2: got %b want 10000", leds);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < RC; i++) begin
      n_checks++;
      if (got_vec !== {5'b00000, 1'b1, 1'b0, 2'd1, 2'd0})
        $display("FAIL lwin_hold[%0d]: got %b want %b", i, got_vec, {5'b00000, 1'b1, 1'b0, 2'd1, 2'd0});
      else n_pass++;
      // Press edge lands on the exit edge; it must be ignored.
      step(i == RC - 1, 1'b0, 1'b0);
    end
    n_checks++;
    if (got_vec !== {5'b00100, 1'b0, 1'b0, 2'd1, 2'd0})
      $display("FAIL lwin_exit: got %b want %b", got_vec, {5'b00100, 1'b0, 1'b0, 2'd1, 2'd0});
    else n_pass++;
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (leds !== 5'b00100) $display("FAIL exit_press_held: got %b want 00100", leds);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (got_vec !== {5'b00100, 1'b0, 1'b0, 2'd1, 2'd0})
      $display("FAIL r_during_lwin: got %b want %b", got_vec, {5'b00100, 1'b0, 1'b0, 2'd1, 2'd0});
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++) begin
      for (int p = 0; p < 3; p++) begin
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
      end
      repeat (RC - 1) step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (right_score !== SW'((w + 1 > SMAX) ? SMAX : w + 1))
        $display("FAIL rscore[%0d]: got %0d want %0d", w, right_score, (w + 1 > SMAX) ? SMAX : w + 1);
      else n_pass++;
      n_checks++;
      if (got_vec !== exp_vec()) $display("FAIL rwin_model[%0d]: got %b want %b", w, got_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_win();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (right_win !== 1'b1) $display("FAIL enter_rwin: got %b want 1", right_win);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (got_vec !== {5'b00100, 1'b0, 1'b0, 2'd0, 2'd0})
      $display("FAIL reset_mid_win: got %b want %b", got_vec, {5'b00100, 1'b0, 1'b0, 2'd0, 2'd0});
    else n_pass++;
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (leds !== 5'b00100) $display("FAIL held_thru_reset: got %b want 00100", leds);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (leds !== 5'b00010) $display("FAIL after_release: got %b want 00010", leds);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0);
      n_checks++;
      if (got_vec !== exp_vec()) begin
        errs++;
        if (errs <= 10) $display("FAIL random[%0d]: got %b want %b", i, got_vec, exp_vec());
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_cancel();
    test_left_win();
    test_saturate();
    test_reset_in_win();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
